// File: rtl/park_space_manager.sv
// Parking occupancy owner: allocates the highest free space with a timed entry gate, releases spaces on exit.
// All outputs registered, one edge after the request; a full lot holds the entry request off until a space is released.
module park_space_manager #(
   parameter int NUM_SPACES  = 8,
   parameter int GATE_CYCLES = 4,
   localparam int IDX_W = $clog2(NUM_SPACES),
   localparam int CNT_W = $clog2(NUM_SPACES + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enter_req,
   input  logic                  exit_req,
   input  logic [IDX_W-1:0]      exit_space,
   output logic [NUM_SPACES-1:0] parking_capacity,
   output logic [IDX_W-1:0]      park_number,
   output logic                  enter_ack,
   output logic                  gate_open,
   output logic                  exit_ack,
   output logic                  exit_error,
   output logic [CNT_W-1:0]      free_count,
   output logic                  full
);

   localparam int GC_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GATE = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t                r_state;
   logic [GC_W-1:0]       r_gate_cnt;
   logic [NUM_SPACES-1:0] r_cap;
   logic [IDX_W-1:0]      r_park_number;
   logic                  r_enter_ack;
   logic                  r_gate_open;
   logic                  r_exit_ack;
   logic                  r_exit_error;
   logic [CNT_W-1:0]      r_free_count;
   logic                  r_full;

   logic [IDX_W-1:0]      w_alloc_idx;
   logic                  w_alloc;
   logic                  w_in_range;
   logic                  w_rel;
   logic                  w_err;
   logic [NUM_SPACES-1:0] w_alloc_mask;
   logic [NUM_SPACES-1:0] w_rel_mask;
   logic [CNT_W-1:0]      w_free_next;

   // Ascending scan: the last set bit seen is the highest free space.
   always_comb begin
      w_alloc_idx = '0;
      for (int i = 0; i < NUM_SPACES; i++) begin
         if (r_cap[i]) begin
            w_alloc_idx = IDX_W'(i);
         end
      end
   end

   assign w_alloc      = (r_state == ST_IDLE) && enter_req && !r_full;
   assign w_in_range   = ({1'b0, exit_space} < (IDX_W + 1)'(NUM_SPACES));
   assign w_rel        = exit_req && w_in_range && !r_cap[exit_space];
   assign w_err        = exit_req && !w_rel;
   assign w_alloc_mask = w_alloc ? (NUM_SPACES'(1) << w_alloc_idx) : '0;
   assign w_rel_mask   = w_rel   ? (NUM_SPACES'(1) << exit_space)  : '0;
   assign w_free_next  = r_free_count + CNT_W'(w_rel) - CNT_W'(w_alloc);

   // Bitmap and counters: allocation sees the pre-update bitmap, so it never picks the space being released.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cap         <= '1;
         r_free_count  <= CNT_W'(NUM_SPACES);
         r_full        <= 1'b0;
         r_exit_ack    <= 1'b0;
         r_exit_error  <= 1'b0;
      end else begin
         r_cap         <= (r_cap & ~w_alloc_mask) | w_rel_mask;
         r_free_count  <= w_free_next;
         r_full        <= (w_free_next == '0);
         r_exit_ack    <= w_rel;
         r_exit_error  <= w_err;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_gate_cnt    <= '0;
         r_park_number <= '0;
         r_enter_ack   <= 1'b0;
         r_gate_open   <= 1'b0;
      end else begin
         r_enter_ack <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_alloc) begin
                  r_park_number <= w_alloc_idx;
                  r_enter_ack   <= 1'b1;
                  r_gate_open   <= 1'b1;
                  r_gate_cnt    <= GC_W'(GATE_CYCLES - 1);
                  r_state       <= ST_GATE;
               end
            end
            ST_GATE: begin
               if (r_gate_cnt == '0) begin
                  r_gate_open <= 1'b0;
                  r_state     <= ST_HOLD;
               end else begin
                  r_gate_cnt <= r_gate_cnt - 1'b1;
               end
            end
            ST_HOLD: begin
               if (!enter_req) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_gate_open <= 1'b0;
            end
         endcase
      end
   end

   assign parking_capacity = r_cap;
   assign park_number      = r_park_number;
   assign enter_ack        = r_enter_ack;
   assign gate_open        = r_gate_open;
   assign exit_ack         = r_exit_ack;
   assign exit_error       = r_exit_error;
   assign free_count       = r_free_count;
   assign full             = r_full;

endmodule

// File: tb/tb_park_space_manager.sv
// Directed bench for park_space_manager: entry gate timing, fill to full, release, error and reset cases.
module tb_park_space_manager;

   localparam int NUM_SPACES  = 8;
   localparam int GATE_CYCLES = 4;
   localparam int IDX_W = $clog2(NUM_SPACES);
   localparam int CNT_W = $clog2(NUM_SPACES + 1);

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  enter_req;
   logic                  exit_req;
   logic [IDX_W-1:0]      exit_space;
   logic [NUM_SPACES-1:0] parking_capacity;
   logic [IDX_W-1:0]      park_number;
   logic                  enter_ack;
   logic                  gate_open;
   logic                  exit_ack;
   logic                  exit_error;
   logic [CNT_W-1:0]      free_count;
   logic                  full;

   int n_total = 0;
   int n_bad   = 0;

   park_space_manager #(
      .NUM_SPACES (NUM_SPACES),
      .GATE_CYCLES(GATE_CYCLES)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .enter_req       (enter_req),
      .exit_req        (exit_req),
      .exit_space      (exit_space),
      .parking_capacity(parking_capacity),
      .park_number     (park_number),
      .enter_ack       (enter_ack),
      .gate_open       (gate_open),
      .exit_ack        (exit_ack),
      .exit_error      (exit_error),
      .free_count      (free_count),
      .full            (full)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete entry from IDLE: allocate, wait out the gate, drop the request, return to IDLE.
   task automatic do_entry(input int exp_idx);
      enter_req = 1'b1;
      tick();
      check("entry_park", 32'(park_number), 32'(exp_idx));
      check("entry_ack", 32'(enter_ack), 32'd1);
      repeat (GATE_CYCLES) tick();
      check("entry_gate_closed", 32'(gate_open), 32'd0);
      enter_req = 1'b0;
      tick();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int gate_cnt;
      int ack_cnt;
      reset      = 1'b1;
      enter_req  = 1'b0;
      exit_req   = 1'b0;
      exit_space = '0;
      tick();
      tick();
      check("rst_cap", 32'(parking_capacity), 32'hFF);
      check("rst_free", 32'(free_count), 32'd8);
      check("rst_full", 32'(full), 32'd0);
      check("rst_park", 32'(park_number), 32'd0);
      check("rst_pulses", {28'd0, enter_ack, gate_open, exit_ack, exit_error}, 32'd0);
      reset = 1'b0;

      // Held request: one allocation, one ack pulse, gate high for exactly GATE_CYCLES.
      enter_req = 1'b1;
      tick();
      check("t1_cap", 32'(parking_capacity), 32'h7F);
      check("t1_park", 32'(park_number), 32'd7);
      check("t1_free", 32'(free_count), 32'd7);
      gate_cnt = int'(gate_open);
      ack_cnt  = int'(enter_ack);
      for (int c = 1; c < 10; c++) begin
         tick();
         gate_cnt += int'(gate_open);
         ack_cnt  += int'(enter_ack);
      end
      check("t1_gate_cycles", 32'(gate_cnt), 32'(GATE_CYCLES));
      check("t1_ack_cycles", 32'(ack_cnt), 32'd1);
      check("t1_no_realloc", 32'(parking_capacity), 32'h7F);
      enter_req = 1'b0;
      tick();

      // Fill the rest of the lot.
      for (int k = 6; k >= 0; k--) do_entry(k);
      check("t2_cap", 32'(parking_capacity), 32'h00);
      check("t2_full", 32'(full), 32'd1);
      check("t2_free", 32'(free_count), 32'd0);

      // Ninth car while full: held off, nothing happens.
      enter_req = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("t2_full_ack", 32'(enter_ack), 32'd0);
         check("t2_full_gate", 32'(gate_open), 32'd0);
      end

      // Release while full with request pending: allocation one edge later.
      exit_req   = 1'b1;
      exit_space = 3'd3;
      tick();
      exit_req = 1'b0;
      check("t3_cap", 32'(parking_capacity), 32'h08);
      check("t3_exit_ack", 32'(exit_ack), 32'd1);
      check("t3_full", 32'(full), 32'd0);
      check("t3_no_alloc_yet", 32'(enter_ack), 32'd0);
      tick();
      check("t3_alloc_ack", 32'(enter_ack), 32'd1);
      check("t3_park", 32'(park_number), 32'd3);
      check("t3_cap2", 32'(parking_capacity), 32'h00);
      check("t3_full2", 32'(full), 32'd1);
      repeat (GATE_CYCLES) tick();
      enter_req = 1'b0;
      tick();

      // Release of an already-free space.
      do_reset();
      exit_req   = 1'b1;
      exit_space = 3'd5;
      tick();
      exit_req = 1'b0;
      check("t4_err", 32'(exit_error), 32'd1);
      check("t4_ack", 32'(exit_ack), 32'd0);
      check("t4_cap", 32'(parking_capacity), 32'hFF);
      check("t4_free", 32'(free_count), 32'd8);
      tick();
      check("t4_err_pulse", 32'(exit_error), 32'd0);

      // Simultaneous allocation and release from 8'h0F.
      for (int k = 7; k >= 4; k--) do_entry(k);
      check("t5_pre_cap", 32'(parking_capacity), 32'h0F);
      enter_req  = 1'b1;
      exit_req   = 1'b1;
      exit_space = 3'd6;
      tick();
      exit_req = 1'b0;
      check("t5_cap", 32'(parking_capacity), 32'h47);
      check("t5_free", 32'(free_count), 32'd4);
      check("t5_park", 32'(park_number), 32'd3);
      check("t5_enter_ack", 32'(enter_ack), 32'd1);
      check("t5_exit_ack", 32'(exit_ack), 32'd1);
      repeat (GATE_CYCLES) tick();
      enter_req = 1'b0;
      tick();

      // Reset during the second gate cycle.
      enter_req = 1'b1;
      tick();
      tick();
      check("t6_gate_pre", 32'(gate_open), 32'd1);
      reset = 1'b1;
      tick();
      check("t6_gate", 32'(gate_open), 32'd0);
      check("t6_cap", 32'(parking_capacity), 32'hFF);
      check("t6_free", 32'(free_count), 32'd8);
      check("t6_pulses", {29'd0, enter_ack, exit_ack, exit_error}, 32'd0);
      reset = 1'b0;
      tick();
      check("t6_idle_alloc", 32'(enter_ack), 32'd1);
      check("t6_idle_park", 32'(park_number), 32'd7);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
